// File: rtl/unidade_acumuladora.sv
// Sequencing/accumulator stage around an external 16-bit ripple adder; optional saturation via `ULA_SATURACAO_EN`.
// Latency: out_valid rises SETTLE_CYCLES edges after the accepting edge, for every op.
// Backpressure: result held stable in DONE until out_ready; no new op accepted until then.
module unidade_acumuladora #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] ACC_RESET     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_s,
    input  logic        add_cout,
    input  logic        add_c15,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_res,
    output logic [3:0]  out_flags,
    output logic [15:0] acc_q
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("unidade_acumuladora: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [3:0] SETTLE_INIT = SETTLE_CYCLES[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] acc_d;

    logic        capture;
    logic        ovf;
    logic [15:0] res_calc;
    logic [3:0]  flags_calc;

    // Handshake outputs derive from state only; in_ready is forced low while reset is held.
    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign out_valid = (state_q == ST_DONE);
    assign out_res   = res_q;
    assign out_flags = flags_q;
    assign capture   = (state_q == ST_CALC) && (cnt_q == 4'd1);

    // Adder operands come from the latched op registers, and only while calculating.
    always_comb begin
        add_a   = 16'h0000;
        add_b   = 16'h0000;
        add_cin = 1'b0;
        if (state_q == ST_CALC) begin
            case (op_q)
                OP_ADD: begin
                    add_a = a_q;
                    add_b = b_q;
                end
                OP_SUB: begin
                    add_a   = a_q;
                    add_b   = ~b_q;
                    add_cin = 1'b1;
                end
                OP_ACC: begin
                    add_a = acc_q;
                    add_b = a_q;
                end
                default: begin
                    add_a   = 16'h0000;
                    add_b   = 16'h0000;
                    add_cin = 1'b0;
                end
            endcase
        end
    end

    // Result and {Z,N,C,V} from the adder; V is carry-out xor carry-into-MSB.
    always_comb begin
        ovf = add_cout ^ add_c15;
`ifdef ULA_SATURACAO_EN
        if (ovf) begin
            // Overflow flips the sign bit, so the true result lies past the opposite rail.
            res_calc = add_s[15] ? 16'h7FFF : 16'h8000;
        end else begin
            res_calc = add_s;
        end
`else
        res_calc = add_s;
`endif
        flags_calc = {(res_calc == 16'h0000), res_calc[15], add_cout, ovf};
        if (op_q == OP_CLR) begin
            res_calc   = 16'h0000;
            flags_calc = 4'b1000;
        end
    end

    // Next-state, counter, operand latching, result capture and accumulator update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = SETTLE_INIT;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (capture) begin
                    cnt_d   = 4'd0;
                    res_d   = res_calc;
                    flags_d = flags_calc;
                    state_d = ST_DONE;
                    if (op_q == OP_ACC) begin
                        acc_d = res_calc;
                    end else if (op_q == OP_CLR) begin
                        acc_d = 16'h0000;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'b00;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            res_q   <= 16'h0000;
            flags_q <= 4'b0000;
            acc_q   <= ACC_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_unidade_acumuladora.sv
// Directed bench for unidade_acumuladora with a behavioural 16-bit adder attached.
// Main instance uses SETTLE_CYCLES=1; a second instance uses 15 for the latency sweep.
// Each scenario task does its own checks and bumps checks/errors.
module tb_unidade_acumuladora;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (SETTLE_CYCLES = 1)
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic [15:0] add_a, add_b, add_s;
    logic        add_cin, add_cout, add_c15;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_res;
    logic [3:0]  out_flags;
    logic [15:0] acc_o;
    logic [16:0] sum1;

    assign sum1     = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
    assign add_s    = sum1[15:0];
    assign add_cout = sum1[16];
    assign add_c15  = add_s[15] ^ add_a[15] ^ add_b[15];

    unidade_acumuladora #(.SETTLE_CYCLES(1), .ACC_RESET(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout), .add_c15(add_c15),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
        .acc_q(acc_o)
    );

    // Latency instance (SETTLE_CYCLES = 15, non-zero reset value)
    logic        l_in_valid = 1'b0;
    logic        l_in_ready;
    logic [1:0]  l_in_op = 2'b00;
    logic [15:0] l_in_a = 16'h0000;
    logic [15:0] l_in_b = 16'h0000;
    logic [15:0] l_add_a, l_add_b, l_add_s;
    logic        l_add_cin, l_add_cout, l_add_c15;
    logic        l_out_valid;
    logic        l_out_ready = 1'b0;
    logic [15:0] l_out_res;
    logic [3:0]  l_out_flags;
    logic [15:0] l_acc_o;
    logic [16:0] sum2;

    assign sum2       = {1'b0, l_add_a} + {1'b0, l_add_b} + {16'b0, l_add_cin};
    assign l_add_s    = sum2[15:0];
    assign l_add_cout = sum2[16];
    assign l_add_c15  = l_add_s[15] ^ l_add_a[15] ^ l_add_b[15];

    unidade_acumuladora #(.SETTLE_CYCLES(15), .ACC_RESET(16'h00A5)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_op(l_in_op), .in_a(l_in_a), .in_b(l_in_b),
        .add_a(l_add_a), .add_b(l_add_b), .add_cin(l_add_cin),
        .add_s(l_add_s), .add_cout(l_add_cout), .add_c15(l_add_c15),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_res(l_out_res), .out_flags(l_out_flags),
        .acc_q(l_acc_o)
    );

    // Issue one op on the main instance, scramble inputs after accept, wait for out_valid.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [3:0] flags,
                          output logic [15:0] acc, output int lat);
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_op = OP_CLR; in_a = 16'hDEAD; in_b = 16'hBEEF;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_res; flags = out_flags; acc = acc_o;
    endtask

    task automatic release_res();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_res !== 16'h0000) begin errors++; $display("FAIL rst_out_res got %h exp 0000", out_res); end
        checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", out_flags); end
        checks++; if (acc_o !== 16'h0000) begin errors++; $display("FAIL rst_acc got %h exp 0000", acc_o); end
        checks++; if (l_acc_o !== 16'h00A5) begin errors++; $display("FAIL rst_acc_l got %h exp 00a5", l_acc_o); end
        checks++; if (add_a !== 16'h0000 || add_b !== 16'h0000 || add_cin !== 1'b0) begin
            errors++; $display("FAIL rst_adder got %h %h %b exp 0000 0000 0", add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_add();
        logic [15:0] r, acc; logic [3:0] f; int lat;
        logic [15:0] exp_r; logic [3:0] exp_f;
        run_op(OP_ADD, 16'h7FFF, 16'h0001, r, f, acc, lat);
`ifdef ULA_SATURACAO_EN
        exp_r = 16'h7FFF; exp_f = 4'b0001;
`else
        exp_r = 16'h8000; exp_f = 4'b0101;
`endif
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_ovf_latency got %0d exp 1", lat); end
        checks++; if (r !== exp_r) begin errors++; $display("FAIL add_ovf_res got %h exp %h", r, exp_r); end
        checks++; if (f !== exp_f) begin errors++; $display("FAIL add_ovf_flags got %b exp %b", f, exp_f); end
        checks++; if (acc !== 16'h0000) begin errors++; $display("FAIL add_ovf_acc got %h exp 0000", acc); end
        release_res();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL add_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
        end
        run_op(OP_ADD, 16'h1234, 16'h1111, r, f, acc, lat);
        checks++; if (r !== 16'h2345) begin errors++; $display("FAIL add_plain_res got %h exp 2345", r); end
        checks++; if (f !== 4'b0000) begin errors++; $display("FAIL add_plain_flags got %b exp 0000", f); end
        release_res();
    endtask

    task automatic test_sub();
        logic [15:0] r, acc; logic [3:0] f; int lat;
        logic [15:0] exp_r; logic [3:0] exp_f;
        run_op(OP_SUB, 16'h0005, 16'h0005, r, f, acc, lat);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL sub_zero_res got %h exp 0000", r); end
        checks++; if (f !== 4'b1010) begin errors++; $display("FAIL sub_zero_flags got %b exp 1010", f); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got %0d exp 1", lat); end
        release_res();
        run_op(OP_SUB, 16'h0000, 16'h0001, r, f, acc, lat);
        checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL sub_borrow_res got %h exp ffff", r); end
        checks++; if (f !== 4'b0100) begin errors++; $display("FAIL sub_borrow_flags got %b exp 0100", f); end
        release_res();
        run_op(OP_SUB, 16'h8000, 16'h0001, r, f, acc, lat);
`ifdef ULA_SATURACAO_EN
        exp_r = 16'h8000; exp_f = 4'b0111;
`else
        exp_r = 16'h7FFF; exp_f = 4'b0011;
`endif
        checks++; if (r !== exp_r) begin errors++; $display("FAIL sub_ovf_res got %h exp %h", r, exp_r); end
        checks++; if (f !== exp_f) begin errors++; $display("FAIL sub_ovf_flags got %b exp %b", f, exp_f); end
        release_res();
    endtask

    task automatic test_acc();
        logic [15:0] r, acc; logic [3:0] f; int lat;
        run_op(OP_CLR, 16'h1111, 16'h2222, r, f, acc, lat);
        checks++; if (r !== 16'h0000 || f !== 4'b1000) begin
            errors++; $display("FAIL clr_res_flags got %h %b exp 0000 1000", r, f);
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL clr_latency got %0d exp 1", lat); end
        release_res();
        run_op(OP_ACC, 16'h0003, 16'h7777, r, f, acc, lat);
        checks++; if (r !== 16'h0003 || acc !== 16'h0003 || f !== 4'b0000) begin
            errors++; $display("FAIL acc_first got res=%h acc=%h flags=%b exp 0003 0003 0000", r, acc, f);
        end
        release_res();
        run_op(OP_ACC, 16'h0003, 16'h0000, r, f, acc, lat);
        checks++; if (r !== 16'h0006 || acc !== 16'h0006) begin
            errors++; $display("FAIL acc_second got res=%h acc=%h exp 0006 0006", r, acc);
        end
        release_res();
        run_op(OP_ADD, 16'h0001, 16'h0001, r, f, acc, lat);
        checks++; if (r !== 16'h0002 || acc !== 16'h0006) begin
            errors++; $display("FAIL add_keeps_acc got res=%h acc=%h exp 0002 0006", r, acc);
        end
        release_res();
        run_op(OP_ACC, 16'hFFFA, 16'h0000, r, f, acc, lat);
        checks++; if (r !== 16'h0000 || acc !== 16'h0000 || f !== 4'b1010) begin
            errors++; $display("FAIL acc_wrap got res=%h acc=%h flags=%b exp 0000 0000 1010", r, acc, f);
        end
        release_res();
    endtask

    task automatic test_backpressure();
        logic [15:0] r, acc; logic [3:0] f; int lat; int bad;
        run_op(OP_ACC, 16'h0005, 16'h0000, r, f, acc, lat);
        checks++; if (r !== 16'h0005 || acc !== 16'h0005) begin
            errors++; $display("FAIL bp_result got res=%h acc=%h exp 0005 0005", r, acc);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = OP_ADD; in_a = 16'h1000 + 16'(i); in_b = 16'h0100;
            if (out_valid !== 1'b1 || out_res !== 16'h0005 || out_flags !== 4'b0000 ||
                in_ready !== 1'b0 || acc_o !== 16'h0005) bad++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0 (valid=%b res=%h acc=%h)", bad, out_valid, out_res, acc_o);
        end
        release_res();
        checks++; if (out_valid !== 1'b0 || acc_o !== 16'h0005) begin
            errors++; $display("FAIL bp_after got valid=%b acc=%h exp 0 0005", out_valid, acc_o);
        end
        // out_ready while idle must not disturb anything.
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_out_ready got ready=%b valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency();
        int lat;
        @(negedge clk);
        l_in_op = OP_ADD; l_in_a = 16'h0002; l_in_b = 16'h0003; l_in_valid = 1'b1;
        @(posedge clk);
        #1;
        l_in_valid = 1'b0; l_in_a = 16'hFFFF;
        lat = 0;
        while (!l_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== 15) begin errors++; $display("FAIL latency15 got %0d exp 15", lat); end
        checks++; if (l_out_res !== 16'h0005 || l_acc_o !== 16'h00A5) begin
            errors++; $display("FAIL latency15_res got res=%h acc=%h exp 0005 00a5", l_out_res, l_acc_o);
        end
        @(negedge clk);
        l_out_ready = 1'b1;
        @(posedge clk);
        #1;
        l_out_ready = 1'b0;
        checks++; if (l_out_valid !== 1'b0) begin errors++; $display("FAIL latency15_release got %b exp 0", l_out_valid); end
    endtask

    task automatic test_reset_mid_calc();
        int bad;
        @(negedge clk);
        in_op = OP_ACC; in_a = 16'h0007; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_pre got valid=%b ready=%b exp 0 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (out_res !== 16'h0000 || out_flags !== 4'b0000 || acc_o !== 16'h0000) begin
            errors++; $display("FAIL mid_rst got res=%h flags=%b acc=%h exp 0000 0000 0000", out_res, out_flags, acc_o);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || acc_o !== 16'h0000) bad++;
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL mid_after got %0d bad cycles exp 0 (valid=%b acc=%h)", bad, out_valid, acc_o);
        end
        checks++; if (l_acc_o !== 16'h00A5) begin errors++; $display("FAIL mid_acc_l got %h exp 00a5", l_acc_o); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_acc();
        test_backpressure();
        test_latency();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
